// File: rtl/vscale_core_scheduler_pkg.sv
// Shared constants for the multicore dmem scheduler: core count, HASTI
// transfer encodings and scheduler FSM state encodings.
package vscale_core_scheduler_pkg;

  localparam int NUM_CORES      = 4;
  localparam int CORE_IDX_WIDTH = 2;

  localparam int HASTI_TRANS_WIDTH = 2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam int SCHED_STATE_WIDTH     = 2;
  localparam int SCHED_QUANTUM_DEFAULT = 4;

  typedef enum logic [SCHED_STATE_WIDTH-1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_OWN    = 2'd1,
    SCHED_LOCK   = 2'd2,
    SCHED_SWITCH = 2'd3
  } sched_state_e;

  // Only NONSEQ and SEQ carry an actual transfer; IDLE and BUSY do not.
  function automatic logic htrans_is_req(input logic [HASTI_TRANS_WIDTH-1:0] t);
    return (t == HASTI_TRANS_NONSEQ) || (t == HASTI_TRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_rr_picker.sv
// Combinational round-robin search: first requesting index at or after
// start, wrapping modulo NUM_CORES.
module vscale_rr_picker
  import vscale_core_scheduler_pkg::*;
(
  input  logic [NUM_CORES-1:0]      req,
  input  logic [CORE_IDX_WIDTH-1:0] start,
  output logic [CORE_IDX_WIDTH-1:0] pick,
  output logic                      found
);

  int unsigned idx;

  // Walk all positions from start, wrapping at NUM_CORES; first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = CORE_IDX_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/vscale_core_scheduler.sv
// Round-robin, quantum-bounded scheduler producing next_core for the
// multicore dmem arbiter. Never re-targets during a stalled transfer or
// while the owner holds hmastlock.
module vscale_core_scheduler
  import vscale_core_scheduler_pkg::*;
#(
  parameter int QUANTUM   = SCHED_QUANTUM_DEFAULT,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HASTI_TRANS_WIDTH-1:0] core_htrans    [0:NUM_CORES-1],
  input  logic                         core_hmastlock [0:NUM_CORES-1],
  input  logic                         dmem_hready,
  output logic [CORE_IDX_WIDTH-1:0]    next_core,
  output logic                         sched_switch,
  output logic [SCHED_STATE_WIDTH-1:0] sched_state
);

  sched_state_e                state_q, state_d;
  logic [CORE_IDX_WIDTH-1:0]   next_core_q, next_core_d;
  logic [CORE_IDX_WIDTH-1:0]   cur_q;
  logic [CNT_WIDTH-1:0]        count_q, count_d;
  logic                        sched_switch_q;

  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        req_others;
  logic [CORE_IDX_WIDTH-1:0]   search_start;
  logic [CORE_IDX_WIDTH-1:0]   pick;
  logic                        other_req;
  logic                        owner_req;
  logic                        owner_lock;
  logic                        eligible;
  logic                        quantum_spent;

  // Saturating increment keeps a lone requester from wrapping back to a
  // small count and looking freshly granted.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Decode requests; the owner is masked out so pick only names other cores.
  always_comb begin
    req        = '0;
    req_others = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i]        = htrans_is_req(core_htrans[i]);
      req_others[i] = req[i] && (CORE_IDX_WIDTH'(i) != next_core_q);
    end
  end

  assign search_start = (next_core_q == CORE_IDX_WIDTH'(NUM_CORES - 1)) ?
                        '0 : next_core_q + 1'b1;

  vscale_rr_picker u_picker (
    .req   (req_others),
    .start (search_start),
    .pick  (pick),
    .found (other_req)
  );

  assign owner_req     = req[next_core_q];
  assign owner_lock    = core_hmastlock[next_core_q];
  assign quantum_spent = (count_q >= CNT_WIDTH'(QUANTUM));
  // cur_q lagging next_core means the arbiter has not yet followed the last move.
  assign eligible      = dmem_hready && !owner_lock && (state_q != SCHED_SWITCH) &&
                         (cur_q == next_core_q);

  // Next-state, grant target and quantum counter.
  always_comb begin
    state_d     = state_q;
    next_core_d = next_core_q;
    count_d     = count_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (dmem_hready && owner_req) begin
          state_d = SCHED_OWN;
          count_d = CNT_WIDTH'(1);
        end else if (dmem_hready && other_req) begin
          state_d     = SCHED_SWITCH;
          next_core_d = pick;
        end
      end
      SCHED_OWN: begin
        if (owner_lock) begin
          state_d = SCHED_LOCK;
        end else if (other_req && eligible && (!owner_req || quantum_spent)) begin
          state_d     = SCHED_SWITCH;
          next_core_d = pick;
        end else if (dmem_hready && !owner_req && !other_req) begin
          state_d = SCHED_IDLE;
        end else if (dmem_hready) begin
          count_d = sat_inc(count_q);
        end
      end
      SCHED_LOCK: begin
        // Leaving with a spent quantum makes the owner yield at once if others wait.
        if (dmem_hready && !owner_lock) begin
          state_d = SCHED_OWN;
          count_d = CNT_WIDTH'(QUANTUM);
        end
      end
      SCHED_SWITCH: begin
        if (owner_req) begin
          state_d = SCHED_OWN;
          count_d = CNT_WIDTH'(1);
        end else begin
          state_d = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // State, grant, arbiter mirror and switch pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= SCHED_IDLE;
      next_core_q    <= '0;
      cur_q          <= '0;
      count_q        <= '0;
      sched_switch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_core_q    <= next_core_d;
      cur_q          <= next_core_q;
      count_q        <= count_d;
      sched_switch_q <= (next_core_d != next_core_q);
    end
  end

  assign next_core    = next_core_q;
  assign sched_switch = sched_switch_q;
  assign sched_state  = state_q;

endmodule

// File: tb/tb_vscale_core_scheduler.sv
// Directed testbench for vscale_core_scheduler (4 cores, QUANTUM=4).
module tb_vscale_core_scheduler;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_OWN = 2'd1, ST_LOCK = 2'd2, ST_SWITCH = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] core_htrans    [0:3];
  logic       core_hmastlock [0:3];
  logic       dmem_hready;
  logic [1:0] next_core;
  logic       sched_switch;
  logic [1:0] sched_state;

  int vectors     = 0;
  int miscompares = 0;

  vscale_core_scheduler #(.QUANTUM(4), .CNT_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_htrans    (core_htrans),
    .core_hmastlock (core_hmastlock),
    .dmem_hready    (dmem_hready),
    .next_core      (next_core),
    .sched_switch   (sched_switch),
    .sched_state    (sched_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] mask, input logic [1:0] kind);
    for (int i = 0; i < 4; i++) core_htrans[i] = mask[i] ? kind : T_IDLE;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    set_req(4'b0000, T_NONSEQ);
    for (int i = 0; i < 4; i++) core_hmastlock[i] = 1'b0;
    dmem_hready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (next_core !== 2'd0) begin miscompares++; $display("FAIL reset_next_core: got %0d want 0", next_core); end
    vectors++; if (sched_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", sched_state, ST_IDLE); end
    vectors++; if (sched_switch !== 1'b0) begin miscompares++; $display("FAIL reset_switch: got %0b want 0", sched_switch); end
    vectors++; if (dut.count_q !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
  endtask

  // All four cores request continuously: 0 held through IDLE + 4 OWN, then 1,2,3,0,1 each 5 cycles.
  task automatic test_round_robin();
    logic [1:0] exp_nc;
    logic       exp_sw;
    int         k;
    apply_reset();
    set_req(4'b1111, T_NONSEQ);
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (e <= 4) begin
        exp_nc = 2'd0;
        exp_sw = 1'b0;
      end else begin
        k      = e - 5;
        exp_nc = 2'((1 + k / 5) % 4);
        exp_sw = (k % 5 == 0);
      end
      vectors++; if (next_core !== exp_nc) begin miscompares++; $display("FAIL rr_next_core edge %0d: got %0d want %0d", e, next_core, exp_nc); end
      vectors++; if (sched_switch !== exp_sw) begin miscompares++; $display("FAIL rr_switch edge %0d: got %0b want %0b", e, sched_switch, exp_sw); end
    end
  endtask

  // Only core 2 requests: one switch to 2, then held forever while count saturates.
  task automatic test_single_core();
    apply_reset();
    set_req(4'b0100, T_SEQ);
    tick();
    vectors++; if (next_core !== 2'd2) begin miscompares++; $display("FAIL single_next_core: got %0d want 2", next_core); end
    vectors++; if (sched_state !== ST_SWITCH) begin miscompares++; $display("FAIL single_state_switch: got %0d want %0d", sched_state, ST_SWITCH); end
    vectors++; if (sched_switch !== 1'b1) begin miscompares++; $display("FAIL single_switch_pulse: got %0b want 1", sched_switch); end
    for (int e = 0; e < 300; e++) begin
      tick();
      vectors++;
      if (next_core !== 2'd2 || sched_switch !== 1'b0 || sched_state !== ST_OWN) begin
        miscompares++;
        $display("FAIL single_hold cycle %0d: got core %0d sw %0b state %0d want core 2 sw 0 state %0d",
                 e, next_core, sched_switch, sched_state, ST_OWN);
      end
    end
    vectors++; if (dut.count_q !== 8'd255) begin miscompares++; $display("FAIL single_count_sat: got %0d want 255", dut.count_q); end
  endtask

  // Stall with count at quantum: nothing moves until hready returns.
  task automatic test_hready_stall();
    apply_reset();
    set_req(4'b0011, T_NONSEQ);
    repeat (4) tick();
    vectors++; if (dut.count_q !== 8'd4) begin miscompares++; $display("FAIL stall_count_pre: got %0d want 4", dut.count_q); end
    dmem_hready = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if (next_core !== 2'd0 || dut.count_q !== 8'd4 || sched_state !== ST_OWN) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: got core %0d count %0d state %0d want core 0 count 4 state %0d",
                 e, next_core, dut.count_q, sched_state, ST_OWN);
      end
    end
    dmem_hready = 1'b1;
    tick();
    vectors++; if (next_core !== 2'd1) begin miscompares++; $display("FAIL stall_release_core: got %0d want 1", next_core); end
    vectors++; if (sched_switch !== 1'b1) begin miscompares++; $display("FAIL stall_release_switch: got %0b want 1", sched_switch); end
  endtask

  // Lock taken at count 3 with core 3 waiting; held 20 cycles, then yield to 3.
  task automatic test_lock();
    apply_reset();
    set_req(4'b1001, T_NONSEQ);
    repeat (3) tick();
    vectors++; if (dut.count_q !== 8'd3) begin miscompares++; $display("FAIL lock_count_pre: got %0d want 3", dut.count_q); end
    core_hmastlock[0] = 1'b1;
    tick();
    vectors++; if (sched_state !== ST_LOCK) begin miscompares++; $display("FAIL lock_enter: got %0d want %0d", sched_state, ST_LOCK); end
    for (int e = 0; e < 20; e++) begin
      tick();
      vectors++;
      if (next_core !== 2'd0 || sched_state !== ST_LOCK) begin
        miscompares++;
        $display("FAIL lock_hold cycle %0d: got core %0d state %0d want core 0 state %0d", e, next_core, sched_state, ST_LOCK);
      end
    end
    core_hmastlock[0] = 1'b0;
    tick();
    vectors++; if (sched_state !== ST_OWN || next_core !== 2'd0) begin miscompares++; $display("FAIL lock_exit: got core %0d state %0d want core 0 state %0d", next_core, sched_state, ST_OWN); end
    vectors++; if (dut.count_q !== 8'd4) begin miscompares++; $display("FAIL lock_exit_count: got %0d want 4", dut.count_q); end
    tick();
    vectors++; if (next_core !== 2'd3) begin miscompares++; $display("FAIL lock_yield_core: got %0d want 3", next_core); end
    vectors++; if (sched_switch !== 1'b1) begin miscompares++; $display("FAIL lock_yield_switch: got %0b want 1", sched_switch); end
  endtask

  // Lock asserted in the very cycle the quantum would expire: lock wins.
  task automatic test_lock_vs_quantum();
    apply_reset();
    set_req(4'b0011, T_NONSEQ);
    repeat (4) tick();
    core_hmastlock[0] = 1'b1;
    dmem_hready = 1'b0;
    tick();
    vectors++; if (sched_state !== ST_LOCK) begin miscompares++; $display("FAIL lockq_state: got %0d want %0d", sched_state, ST_LOCK); end
    vectors++; if (next_core !== 2'd0) begin miscompares++; $display("FAIL lockq_core: got %0d want 0", next_core); end
  endtask

  // Owner 3 goes idle while core 1 waits: search wraps 3 -> 0 -> 1.
  task automatic test_wrap();
    apply_reset();
    set_req(4'b1000, T_NONSEQ);
    tick();
    vectors++; if (next_core !== 2'd3) begin miscompares++; $display("FAIL wrap_to3: got %0d want 3", next_core); end
    tick();
    vectors++; if (sched_state !== ST_OWN) begin miscompares++; $display("FAIL wrap_own3: got %0d want %0d", sched_state, ST_OWN); end
    set_req(4'b0010, T_SEQ);
    tick();
    vectors++; if (next_core !== 2'd1) begin miscompares++; $display("FAIL wrap_to1: got %0d want 1", next_core); end
    vectors++; if (sched_switch !== 1'b1) begin miscompares++; $display("FAIL wrap_switch: got %0b want 1", sched_switch); end
  endtask

  // Reset raised during SWITCH clears outputs without waiting for a clock edge.
  task automatic test_async_reset();
    apply_reset();
    set_req(4'b0100, T_NONSEQ);
    tick();
    vectors++; if (next_core !== 2'd2 || sched_state !== ST_SWITCH) begin miscompares++; $display("FAIL areset_pre: got core %0d state %0d want core 2 state %0d", next_core, sched_state, ST_SWITCH); end
    reset = 1'b1;
    #1;
    vectors++; if (next_core !== 2'd0) begin miscompares++; $display("FAIL areset_core: got %0d want 0", next_core); end
    vectors++; if (sched_state !== ST_IDLE) begin miscompares++; $display("FAIL areset_state: got %0d want %0d", sched_state, ST_IDLE); end
    vectors++; if (sched_switch !== 1'b0) begin miscompares++; $display("FAIL areset_switch: got %0b want 0", sched_switch); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    dmem_hready = 1'b1;
    set_req(4'b0000, T_NONSEQ);
    for (int i = 0; i < 4; i++) core_hmastlock[i] = 1'b0;
    test_reset();
    test_round_robin();
    test_single_core();
    test_hready_stall();
    test_lock();
    test_lock_vs_quantum();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
